rx_timer: RTL and testbench

Bit-timing and bit-unstuffing controller for the USB full-speed receive path. Recovers the bit clock from the oversampled line, issues the per-bit sample strobe to the NRZI decoder and receive shift register, discards stuffed bits after six consecutive decoded ones, and flags each completed byte. Sits between the edge detector and EOP detector (inputs) and the NRZI decoder and receive shift register (outputs), under the RX control FSM.

---
 rtl/rx_timer.sv | 120 ++++++++++++
 tb/tb_rx_timer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rx_timer.sv
// USB full-speed receive bit timer: recovers bit timing from D+ edges, strobes the
// NRZI decoder, drops stuffed bits and flags whole bytes. Optional: RX_TIMER_STUFF_ERR_EN.
module rx_timer #(
    parameter int CLKS_PER_BIT = 8,
    parameter int SAMPLE_PHASE = 3,
    parameter int STUFF_LIMIT  = 6
) (
    input  logic clk,
    input  logic n_rst,
    input  logic rcving,
    input  logic d_edge,
    input  logic eop,
    input  logic d_orig,
    output logic shift_enable,
    output logic data_shift,
`ifdef RX_TIMER_STUFF_ERR_EN
    output logic stuff_err,
`endif
    output logic byte_received
);

    localparam int PH_W   = $clog2(CLKS_PER_BIT);
    localparam int ONES_W = $clog2(STUFF_LIMIT + 1);

    localparam logic [PH_W-1:0]   PH_ZERO   = '0;
    localparam logic [PH_W-1:0]   PH_ONE    = PH_W'(1);
    localparam logic [PH_W-1:0]   PH_LAST   = PH_W'(CLKS_PER_BIT - 1);
    localparam logic [PH_W-1:0]   PH_SAMPLE = PH_W'(SAMPLE_PHASE);
    localparam logic [ONES_W-1:0] ONES_ZERO = '0;
    localparam logic [ONES_W-1:0] ONES_ONE  = ONES_W'(1);
    localparam logic [ONES_W-1:0] ONES_MAX  = ONES_W'(STUFF_LIMIT);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t            r_state;
    logic [PH_W-1:0]   r_ph;
    logic              r_bit_valid;
    logic [ONES_W-1:0] r_ones;
    logic [2:0]        r_bitcnt;
    logic              r_byte_rcvd;

    logic w_stuff;
    logic w_data;

    // A bit sampled while the ones run has reached the limit is the inserted stuff bit.
    assign w_stuff       = (r_ones == ONES_MAX);
    assign w_data        = r_bit_valid & ~w_stuff;
    assign shift_enable  = (r_state == RUN) && (r_ph == PH_SAMPLE) && !eop;
    assign data_shift    = w_data;
    assign byte_received = r_byte_rcvd;
`ifdef RX_TIMER_STUFF_ERR_EN
    assign stuff_err     = r_bit_valid & w_stuff & d_orig;
`endif

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_state     <= IDLE;
            r_ph        <= PH_ZERO;
            r_bit_valid <= 1'b0;
            r_ones      <= ONES_ZERO;
            r_bitcnt    <= 3'd0;
            r_byte_rcvd <= 1'b0;
        end else begin
            r_bit_valid <= shift_enable & rcving;
            r_byte_rcvd <= 1'b0;
            if (!rcving) begin
                r_state  <= IDLE;
                r_ph     <= PH_ZERO;
                r_ones   <= ONES_ZERO;
                r_bitcnt <= 3'd0;
            end else begin
                case (r_state)
                    IDLE: begin
                        // rcving rises on the first edge, so that cycle is phase 0
                        r_state <= RUN;
                        r_ph    <= PH_ONE;
                    end
                    RUN: begin
                        if (w_data && (r_bitcnt == 3'd7)) begin
                            r_byte_rcvd <= 1'b1;
                        end
                        if (eop) begin
                            r_state  <= HALT;
                            r_ph     <= PH_ZERO;
                            r_ones   <= ONES_ZERO;
                            r_bitcnt <= 3'd0;
                        end else begin
                            if (d_edge) begin
                                r_ph <= PH_ONE;
                            end else if (r_ph == PH_LAST) begin
                                r_ph <= PH_ZERO;
                            end else begin
                                r_ph <= r_ph + PH_ONE;
                            end
                            if (r_bit_valid) begin
                                if (w_stuff) begin
                                    r_ones <= ONES_ZERO;
                                end else begin
                                    r_ones   <= d_orig ? (r_ones + ONES_ONE) : ONES_ZERO;
                                    r_bitcnt <= r_bitcnt + 3'd1;
                                end
                            end
                        end
                    end
                    HALT: begin
                        r_state <= HALT;
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_rx_timer.sv
// Self-checking bench for rx_timer: reset table, directed packets and random packets
// compared cycle by cycle against a timing/bitstream reference model.
module tb_rx_timer;

    localparam int CPB = 8;
    localparam int SP  = 3;
    localparam int SL  = 6;

    logic clk = 1'b0;
    logic n_rst, rcving, d_edge, eop, d_orig;
    logic shift_enable, data_shift, byte_received;
`ifdef RX_TIMER_STUFF_ERR_EN
    logic stuff_err;
`endif

    rx_timer #(.CLKS_PER_BIT(CPB), .SAMPLE_PHASE(SP), .STUFF_LIMIT(SL)) dut (
        .clk(clk),
        .n_rst(n_rst),
        .rcving(rcving),
        .d_edge(d_edge),
        .eop(eop),
        .d_orig(d_orig),
        .shift_enable(shift_enable),
        .data_shift(data_shift),
`ifdef RX_TIMER_STUFF_ERR_EN
        .stuff_err(stuff_err),
`endif
        .byte_received(byte_received)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // packet description: decoded bit values and their line durations in clocks
    bit q_bits[$];
    int q_lens[$];
    bit isdata[$];
    bit iserr[$];

    // model: sync time, pending sampled bit, data-bit count within packet
    bit m_run  = 0;
    bit m_halt = 0;
    int m_t    = 0;
    int m_t0   = 0;
    bit m_pend = 0;
    int m_pidx = 0;
    int m_bi   = 0;
    int m_dcnt = 0;
    bit m_br   = 0;

    int cnt_se, cnt_ds, cnt_br, cnt_err;

    typedef struct {
        bit rcv, edg, e, d;
        bit se, ds, br;
    } vec_t;
    vec_t tbl[14];

    task automatic check(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0b required=%0b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_int(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    // A bit is stuffing iff it directly follows SL consecutive data ones.
    function automatic void classify();
        int ones = 0;
        isdata.delete();
        iserr.delete();
        foreach (q_bits[i]) begin
            if (ones == SL) begin
                isdata.push_back(1'b0);
                iserr.push_back(q_bits[i]);
                ones = 0;
            end else begin
                isdata.push_back(1'b1);
                iserr.push_back(1'b0);
                ones = q_bits[i] ? ones + 1 : 0;
            end
        end
    endfunction

    function automatic void clear_counts();
        cnt_se = 0; cnt_ds = 0; cnt_br = 0; cnt_err = 0;
    endfunction

    task automatic step(input bit rcv, input bit edg, input bit e);
        bit exp_se, exp_ds, exp_br, pv;
        int ph;
`ifdef RX_TIMER_STUFF_ERR_EN
        bit exp_err;
`endif
        pv     = m_pend && (m_pidx < q_bits.size());
        rcving = rcv;
        d_edge = edg;
        eop    = e;
        d_orig = pv ? q_bits[m_pidx] : 1'($urandom_range(0, 1));
        ph     = (m_t - m_t0) % CPB;
        exp_se = m_run && !m_halt && (ph == SP) && !e;
        exp_ds = pv && isdata[m_pidx];
        exp_br = m_br;
`ifdef RX_TIMER_STUFF_ERR_EN
        exp_err = pv && iserr[m_pidx];
`endif
        @(negedge clk);
        check("shift_enable", shift_enable, exp_se);
        check("data_shift", data_shift, exp_ds);
        check("byte_received", byte_received, exp_br);
        if (shift_enable) cnt_se++;
        if (data_shift) cnt_ds++;
        if (byte_received) cnt_br++;
`ifdef RX_TIMER_STUFF_ERR_EN
        check("stuff_err", stuff_err, exp_err);
        if (stuff_err) cnt_err++;
`endif
        m_br = rcv && exp_ds && (((m_dcnt + 1) % 8) == 0);
        if (exp_ds) m_dcnt++;
        if (!rcv) begin
            m_run = 0; m_halt = 0; m_dcnt = 0;
        end else if (!m_run) begin
            m_run = 1; m_t0 = m_t;
        end else if (!m_halt) begin
            if (e) begin
                m_halt = 1; m_dcnt = 0;
            end else if (edg) begin
                m_t0 = m_t;
            end
        end
        m_pend = exp_se && rcv;
        m_pidx = m_bi;
        if (exp_se) m_bi++;
        m_t++;
        @(posedge clk);
        #1;
    endtask

    // Line edge at each bit start where NRZI encodes a 0; rcving rises on the first edge.
    task automatic run_packet(input int eop_at);
        int t = 0;
        classify();
        m_bi = 0;
        for (int i = 0; i < q_lens.size(); i++) begin
            for (int c = 0; c < q_lens[i]; c++) begin
                step(1'b1, (c == 0) && ((i == 0) || !q_bits[i]), (eop_at >= 0) && (t >= eop_at));
                t++;
            end
        end
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
    endtask

    task automatic set_uniform(input int n, input bit v, input int len);
        q_bits.delete();
        q_lens.delete();
        for (int i = 0; i < n; i++) begin
            q_bits.push_back(v);
            q_lens.push_back(len);
        end
    endtask

    initial begin
        n_rst = 1'b0; rcving = 1'b0; d_edge = 1'b0; eop = 1'b0; d_orig = 1'b0;

        // reset state
        @(negedge clk);
        check("reset_se", shift_enable, 1'b0);
        check("reset_ds", data_shift, 1'b0);
        check("reset_br", byte_received, 1'b0);
        @(posedge clk); #1;
        n_rst = 1'b1;

        // table: start of packet, two sampled bits, one resync edge, eop, exit
        tbl[0]  = '{1,0,0,0, 0,0,0};
        tbl[1]  = '{1,0,0,0, 0,0,0};
        tbl[2]  = '{1,0,0,0, 0,0,0};
        tbl[3]  = '{1,0,0,0, 1,0,0};
        tbl[4]  = '{1,0,0,1, 0,1,0};
        tbl[5]  = '{1,1,0,0, 0,0,0};
        tbl[6]  = '{1,0,0,0, 0,0,0};
        tbl[7]  = '{1,0,0,0, 0,0,0};
        tbl[8]  = '{1,0,0,0, 1,0,0};
        tbl[9]  = '{1,0,0,0, 0,1,0};
        tbl[10] = '{1,0,1,0, 0,0,0};
        tbl[11] = '{1,0,1,0, 0,0,0};
        tbl[12] = '{0,0,0,0, 0,0,0};
        tbl[13] = '{0,0,0,0, 0,0,0};
        for (int i = 0; i < 14; i++) begin
            rcving = tbl[i].rcv; d_edge = tbl[i].edg; eop = tbl[i].e; d_orig = tbl[i].d;
            @(negedge clk);
            check($sformatf("tbl%0d_se", i), shift_enable, tbl[i].se);
            check($sformatf("tbl%0d_ds", i), data_shift, tbl[i].ds);
            check($sformatf("tbl%0d_br", i), byte_received, tbl[i].br);
            @(posedge clk); #1;
        end

        // sync 0x80 then 0xA5, both LSB first, 8 clocks per bit
        q_bits = '{0,0,0,0,0,0,0,1, 1,0,1,0,0,1,0,1};
        q_lens = '{8,8,8,8,8,8,8,8, 8,8,8,8,8,8,8,8};
        clear_counts();
        run_packet(-1);
        check_int("A_se_count", cnt_se, 16);
        check_int("A_ds_count", cnt_ds, 16);
        check_int("A_br_count", cnt_br, 2);

        // eight ones with the stuffed zero after the sixth
        q_bits = '{1,1,1,1,1,1,0,1,1};
        q_lens = '{8,8,8,8,8,8,8,8,8};
        clear_counts();
        run_packet(-1);
        check_int("B_ds_count", cnt_ds, 8);
        check_int("B_br_count", cnt_br, 1);

        // drift: five 7-clock bits then five 9-clock bits, edge on each
        set_uniform(10, 1'b0, 7);
        for (int i = 5; i < 10; i++) q_lens[i] = 9;
        clear_counts();
        run_packet(-1);
        check_int("C_se_count", cnt_se, 10);
        check_int("C_ds_count", cnt_ds, 10);

        // eop on the cycle the sixth strobe is due
        set_uniform(8, 1'b0, 8);
        clear_counts();
        run_packet(5 * 8 + SP);
        check_int("D_se_count", cnt_se, 5);
        check_int("D_ds_count", cnt_ds, 5);
        check_int("D_br_count", cnt_br, 0);

        // seven ones: the seventh sits in the stuff position
        set_uniform(7, 1'b1, 8);
        clear_counts();
        run_packet(-1);
        check_int("E_ds_count", cnt_ds, 6);
`ifdef RX_TIMER_STUFF_ERR_EN
        check_int("E_err_count", cnt_err, 1);
`endif

        // asynchronous reset while a strobe is active
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rcving = 1'b1; d_edge = 1'b0; eop = 1'b0;
        @(negedge clk);
        check("rst_pre_se", shift_enable, 1'b1);
        n_rst = 1'b0;
        #1;
        check("rst_se", shift_enable, 1'b0);
        check("rst_ds", data_shift, 1'b0);
        check("rst_br", byte_received, 1'b0);
        @(posedge clk); #1;
        check("rst_hold_ds", data_shift, 1'b0);
        rcving = 1'b0;
        @(posedge clk); #1;
        n_rst = 1'b1;
        m_run = 0; m_halt = 0; m_pend = 0; m_br = 0; m_dcnt = 0;
        step(1'b0, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b0);

        // random packets: ones-heavy data, jittered bit lengths, occasional early eop
        for (int p = 0; p < 25; p++) begin
            int n;
            int eop_at;
            q_bits.delete();
            q_lens.delete();
            n = $urandom_range(10, 40);
            for (int i = 0; i < n; i++) begin
                q_bits.push_back($urandom_range(0, 3) != 0);
                q_lens.push_back($urandom_range(6, 10));
            end
            for (int i = 0; i < 8; i++) q_bits.push_back(1'($urandom_range(0, 1)));
            eop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(5, 150) : -1;
            run_packet(eop_at);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
